maxpool_lanes: RTL and testbench



---
 rtl/maxpool_lanes_if.sv | 28 ++
 rtl/maxpool_lanes.sv | 87 ++++++++
 tb/tb_maxpool_lanes.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_lanes_if.sv
// rtl/maxpool_lanes_if.sv - stream and control bundle for the lane-parallel max-pooling unit
interface maxpool_lanes_if #(
  parameter int LANES  = 32,
  parameter int DATA_W = 32,
  parameter int CW     = 5
);
  logic [CW-1:0]           win_len;
  logic [LANES-1:0]        lane_en;
  logic                    relu_en;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic [CW-1:0]           out_count;

  modport master (
    output win_len, lane_en, relu_en, flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  win_len, lane_en, relu_en, flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/maxpool_lanes.sv
// rtl/maxpool_lanes.sv - lane-parallel windowed max reduction with flush, ReLU and lane enables
module maxpool_lanes #(
  parameter int LANES   = 32,
  parameter int DATA_W  = 32,
  parameter int WIN_MAX = 16,
  parameter int SIGNED  = 1
) (
  input logic           clk,
  input logic           rst_n,
  maxpool_lanes_if.slave bus
);
  localparam int CW = $clog2(WIN_MAX) + 1;
  localparam logic [CW-1:0] WMAX = CW'(WIN_MAX);

  logic [CW-1:0]           cnt, cnt_nxt, win_eff, win_in, win_cur;
  logic [LANES-1:0]        en_q, en_cur;
  logic [LANES*DATA_W-1:0] acc, acc_nxt, res_nxt;
  logic [DATA_W-1:0]       a, b, m;
  logic                    accept, first, close, gt;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign first        = (cnt == '0);
  assign cnt_nxt      = accept ? cnt + 1'b1 : cnt;

  always_comb begin
    win_in = bus.win_len;
    if (bus.win_len == '0)
      win_in = CW'(1);
    else if (bus.win_len > WMAX)
      win_in = WMAX;
  end

  // The first beat of a window already uses the freshly sampled length and enables.
  assign win_cur = first ? win_in : win_eff;
  assign en_cur  = first ? bus.lane_en : en_q;

  // A flush-only close needs a free (or draining) output slot, same as a beat close.
  assign close = (accept && (cnt_nxt == win_cur)) ||
                 (bus.flush && bus.in_ready && (cnt_nxt != '0));

  always_comb begin
    acc_nxt = acc;
    res_nxt = '0;
    a  = '0;
    b  = '0;
    m  = '0;
    gt = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      a  = bus.in_data[i*DATA_W +: DATA_W];
      b  = acc[i*DATA_W +: DATA_W];
      gt = (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
      if (accept)
        acc_nxt[i*DATA_W +: DATA_W] = (first || gt) ? a : b;
      m = acc_nxt[i*DATA_W +: DATA_W];
      if (bus.relu_en && (SIGNED != 0) && m[DATA_W-1])
        m = '0;
      res_nxt[i*DATA_W +: DATA_W] = en_cur[i] ? m : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      win_eff       <= CW'(1);
      en_q          <= '1;
      acc           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_count <= '0;
    end else begin
      acc <= acc_nxt;
      if (accept && first) begin
        win_eff <= win_in;
        en_q    <= bus.lane_en;
      end
      cnt <= close ? '0 : cnt_nxt;
      if (close) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= res_nxt;
        bus.out_count <= cnt_nxt;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_maxpool_lanes.sv
// tb/tb_maxpool_lanes.sv - randomized and directed bench for maxpool_lanes, signed and unsigned builds
module tb_maxpool_lanes;
  localparam int L  = 32;
  localparam int W  = 32;
  localparam int WM = 16;
  localparam int CW = 5;
  typedef logic [L*W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  maxpool_lanes_if #(.LANES(L), .DATA_W(W), .CW(CW)) bs ();
  maxpool_lanes_if #(.LANES(L), .DATA_W(W), .CW(CW)) bu ();

  assign bu.win_len   = bs.win_len;
  assign bu.lane_en   = bs.lane_en;
  assign bu.relu_en   = bs.relu_en;
  assign bu.flush     = bs.flush;
  assign bu.in_valid  = bs.in_valid;
  assign bu.in_data   = bs.in_data;
  assign bu.out_ready = bs.out_ready;

  maxpool_lanes #(.LANES(L), .DATA_W(W), .WIN_MAX(WM), .SIGNED(1)) u_s (
    .clk(clk), .rst_n(rst_n), .bus(bs.slave));
  maxpool_lanes #(.LANES(L), .DATA_W(W), .WIN_MAX(WM), .SIGNED(0)) u_u (
    .clk(clk), .rst_n(rst_n), .bus(bu.slave));

  // Reference: the open window is kept as a list of beats and reduced only when it closes.
  vec_t       beats[$];
  int         m_win;
  logic [L-1:0] m_en;
  logic       exp_valid;
  vec_t       exp_s, exp_u;
  int         exp_count;
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic int eff(input logic [CW-1:0] w);
    if (w == 0) return 1;
    if (w > WM) return WM;
    return int'(w);
  endfunction

  function automatic vec_t pool(input bit sgn, input bit relu, input logic [L-1:0] en);
    vec_t r;
    logic [W-1:0] v, mx;
    r = '0;
    for (int ln = 0; ln < L; ln++) begin
      mx = beats[0][ln*W +: W];
      for (int k = 1; k < beats.size(); k++) begin
        v = beats[k][ln*W +: W];
        if (sgn ? ($signed(v) > $signed(mx)) : (v > mx)) mx = v;
      end
      if (sgn && relu && mx[W-1]) mx = '0;
      r[ln*W +: W] = en[ln] ? mx : '0;
    end
    return r;
  endfunction

  function automatic int diff_lane(input vec_t x, input vec_t y);
    for (int ln = 0; ln < L; ln++)
      if (x[ln*W +: W] !== y[ln*W +: W]) return ln;
    return 0;
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    for (int ln = 0; ln < L; ln++)
      r[ln*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
    return r;
  endfunction

  function automatic vec_t set_lane(input vec_t base, input int ln, input logic [W-1:0] val);
    vec_t r;
    r = base;
    r[ln*W +: W] = val;
    return r;
  endfunction

  task automatic model_reset();
    beats.delete();
    exp_valid = 1'b0;
    exp_s     = '0;
    exp_u     = '0;
    exp_count = 0;
  endtask

  task automatic step(input bit v, input vec_t d, input bit fl, input bit ordy);
    bit rdy, acc;
    bs.in_valid  = v;
    bs.in_data   = d;
    bs.flush     = fl;
    bs.out_ready = ordy;
    rdy = !exp_valid || ordy;
    acc = v && rdy;
    if (acc) begin
      if (beats.size() == 0) begin
        m_win = eff(bs.win_len);
        m_en  = bs.lane_en;
      end
      beats.push_back(d);
    end
    if (beats.size() > 0 && ((acc && beats.size() == m_win) || (fl && rdy))) begin
      exp_s     = pool(1'b1, bs.relu_en, m_en);
      exp_u     = pool(1'b0, bs.relu_en, m_en);
      exp_count = beats.size();
      exp_valid = 1'b1;
      beats.delete();
    end else if (ordy) begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bs.win_len = '0; bs.lane_en = '1; bs.relu_en = 1'b0; bs.flush = 1'b0;
    bs.in_valid = 1'b0; bs.in_data = '0; bs.out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bs.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bs.in_ready); end
    n_checks++; if (bs.out_valid !== 1'b0 || bu.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b/%b expected 0", bs.out_valid, bu.out_valid); end
    n_checks++; if (bs.out_data !== '0 || bu.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: lane %0d got %h expected 0", diff_lane(bs.out_data, '0), bs.out_data[diff_lane(bs.out_data, '0)*W +: W]); end
    n_checks++; if (bs.out_count !== '0) begin n_fail++; $display("FAIL reset_out_count: got %0d expected 0", bs.out_count); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned_window();
    int vals[4] = '{3, 9, 2, 7};
    bs.win_len = 5'd4; bs.lane_en = '1; bs.relu_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, set_lane(rand_vec(), 0, W'(vals[k])), 1'b0, 1'b1);
      if (k < 3) begin
        n_checks++; if (bu.out_valid !== 1'b0) begin n_fail++; $display("FAIL uns_early_valid: beat %0d got %b expected 0", k, bu.out_valid); end
      end
    end
    n_checks++; if (bu.out_valid !== 1'b1) begin n_fail++; $display("FAIL uns_valid: got %b expected 1", bu.out_valid); end
    n_checks++; if (bu.out_data[0 +: W] !== 32'd9) begin n_fail++; $display("FAIL uns_lane0: got %0d expected 9", bu.out_data[0 +: W]); end
    n_checks++; if (bu.out_data !== exp_u) begin n_fail++; $display("FAIL uns_all_lanes: lane %0d got %h expected %h", diff_lane(bu.out_data, exp_u), bu.out_data[diff_lane(bu.out_data, exp_u)*W +: W], exp_u[diff_lane(bu.out_data, exp_u)*W +: W]); end
    n_checks++; if (bu.out_count !== 5'd4) begin n_fail++; $display("FAIL uns_count: got %0d expected 4", bu.out_count); end
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (bu.out_valid !== 1'b0) begin n_fail++; $display("FAIL uns_drain: got %b expected 0", bu.out_valid); end
  endtask

  task automatic test_signed_relu();
    logic [W-1:0] want;
    bs.win_len = 5'd2; bs.lane_en = '1;
    for (int r = 0; r < 2; r++) begin
      bs.relu_en = r[0];
      step(1'b1, set_lane(rand_vec(), 5, -32'sd8), 1'b0, 1'b1);
      step(1'b1, set_lane(rand_vec(), 5, -32'sd3), 1'b0, 1'b1);
      want = r[0] ? 32'd0 : 32'hFFFF_FFFD;
      n_checks++; if (bs.out_data[5*W +: W] !== want) begin n_fail++; $display("FAIL relu%0d_lane5: got %h expected %h", r, bs.out_data[5*W +: W], want); end
      n_checks++; if (bs.out_data !== exp_s || bu.out_data !== exp_u) begin n_fail++; $display("FAIL relu%0d_all_lanes: lane %0d got %h expected %h", r, diff_lane(bs.out_data, exp_s), bs.out_data[diff_lane(bs.out_data, exp_s)*W +: W], exp_s[diff_lane(bs.out_data, exp_s)*W +: W]); end
    end
    bs.relu_en = 1'b0;
  endtask

  task automatic test_flush_enables();
    int vals[3] = '{1, 4, 2};
    bs.win_len = 5'd8;
    for (int e = 0; e < 2; e++) begin
      bs.lane_en = e[0] ? 32'hFFFF_FFFD : '1;
      for (int k = 0; k < 3; k++) begin
        step(1'b1, set_lane(rand_vec(), 1, W'(vals[k])), 1'b0, 1'b1);
        bs.lane_en = '1;
        bs.win_len = 5'd2;
      end
      step(1'b0, '0, 1'b1, 1'b1);
      bs.win_len = 5'd8;
      n_checks++; if (bs.out_valid !== 1'b1 || bs.out_count !== 5'd3) begin n_fail++; $display("FAIL flush%0d_close: valid %b count %0d expected 1/3", e, bs.out_valid, bs.out_count); end
      n_checks++; if (bs.out_data[1*W +: W] !== (e[0] ? 32'd0 : 32'd4)) begin n_fail++; $display("FAIL flush%0d_lane1: got %0d expected %0d", e, bs.out_data[1*W +: W], e[0] ? 0 : 4); end
      n_checks++; if (bs.out_data !== exp_s) begin n_fail++; $display("FAIL flush%0d_all_lanes: lane %0d got %h expected %h", e, diff_lane(bs.out_data, exp_s), bs.out_data[diff_lane(bs.out_data, exp_s)*W +: W], exp_s[diff_lane(bs.out_data, exp_s)*W +: W]); end
    end
    bs.lane_en = '1;
  endtask

  task automatic test_backpressure();
    vec_t held;
    bs.win_len = 5'd1;
    step(1'b1, rand_vec(), 1'b0, 1'b0);
    held = bs.out_data;
    for (int c = 0; c < 5; c++) begin
      bs.out_ready = 1'b0;
      #1;
      n_checks++; if (bs.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b expected 0", c, bs.in_ready); end
      step(1'b1, rand_vec(), 1'b0, 1'b0);
      n_checks++; if (bs.out_valid !== 1'b1 || bs.out_data !== held) begin n_fail++; $display("FAIL bp_hold: cycle %0d valid %b lane %0d got %h", c, bs.out_valid, diff_lane(bs.out_data, held), bs.out_data[diff_lane(bs.out_data, held)*W +: W]); end
    end
    step(1'b1, rand_vec(), 1'b0, 1'b1);
    n_checks++; if (bs.out_valid !== 1'b1 || bs.out_data !== exp_s || bu.out_data !== exp_u) begin n_fail++; $display("FAIL bp_reload: valid %b lane %0d got %h expected %h", bs.out_valid, diff_lane(bs.out_data, exp_s), bs.out_data[diff_lane(bs.out_data, exp_s)*W +: W], exp_s[diff_lane(bs.out_data, exp_s)*W +: W]); end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    bs.win_len = 5'd0;
    for (int k = 0; k < 10; k++) begin
      bs.out_ready = 1'b1;
      #1;
      n_checks++; if (bs.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: beat %0d got %b expected 1", k, bs.in_ready); end
      step(1'b1, rand_vec(), 1'b0, 1'b1);
      n_checks++; if (bs.out_valid !== 1'b1 || bs.out_count !== 5'd1 || bu.out_data !== exp_u) begin n_fail++; $display("FAIL b2b_result: beat %0d valid %b count %0d lane %0d got %h expected %h", k, bs.out_valid, bs.out_count, diff_lane(bu.out_data, exp_u), bu.out_data[diff_lane(bu.out_data, exp_u)*W +: W], exp_u[diff_lane(bu.out_data, exp_u)*W +: W]); end
    end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_boundaries();
    bs.win_len = 5'd31;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, rand_vec(), 1'b0, 1'b1);
      if (k == 14) begin
        n_checks++; if (bs.out_valid !== 1'b0) begin n_fail++; $display("FAIL win31_early: got %b expected 0", bs.out_valid); end
      end
    end
    n_checks++; if (bs.out_valid !== 1'b1 || bs.out_count !== 5'd16 || bs.out_data !== exp_s) begin n_fail++; $display("FAIL win31_close: valid %b count %0d expected 1/16", bs.out_valid, bs.out_count); end
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    n_checks++; if (bs.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_flush: got %b expected 0", bs.out_valid); end
  endtask

  task automatic test_reset_mid_window();
    int vals[4] = '{5, 1, 1, 1};
    bs.win_len = 5'd4;
    step(1'b1, {L{32'd9}}, 1'b0, 1'b1);
    step(1'b1, {L{32'd9}}, 1'b0, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bs.out_valid !== 1'b0 || bs.out_count !== '0) begin n_fail++; $display("FAIL rst_mid_outputs: valid %b count %0d expected 0/0", bs.out_valid, bs.out_count); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, {L{W'(vals[k])}}, 1'b0, 1'b1);
      if (k == 1) begin
        n_checks++; if (bs.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale: got %b expected 0", bs.out_valid); end
      end
    end
    n_checks++; if (bs.out_valid !== 1'b1 || bs.out_count !== 5'd4 || bs.out_data !== {L{32'd5}}) begin n_fail++; $display("FAIL rst_mid_result: valid %b count %0d lane0 %0d expected 1/4/5", bs.out_valid, bs.out_count, bs.out_data[0 +: W]); end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    bit v, fl, ordy;
    for (int c = 0; c < 2000; c++) begin
      bs.win_len = CW'($urandom_range(0, 31));
      bs.lane_en = ($urandom_range(0, 2) == 0) ? L'($urandom) : '1;
      bs.relu_en = $urandom_range(0, 1);
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 7) == 0) && (!exp_valid || ordy);
      bs.out_ready = ordy;
      #1;
      n_checks++; if (bs.in_ready !== (!exp_valid || ordy)) begin n_fail++; $display("FAIL rnd_in_ready: cycle %0d got %b expected %b", c, bs.in_ready, !exp_valid || ordy); end
      step(v, rand_vec(), fl, ordy);
      n_checks++; if (bs.out_valid !== exp_valid || bu.out_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid: cycle %0d got %b/%b expected %b", c, bs.out_valid, bu.out_valid, exp_valid); end
      if (exp_valid) begin
        n_checks++; if (bs.out_count !== CW'(exp_count)) begin n_fail++; $display("FAIL rnd_count: cycle %0d got %0d expected %0d", c, bs.out_count, exp_count); end
        n_checks++; if (bs.out_data !== exp_s) begin n_fail++; $display("FAIL rnd_signed: cycle %0d lane %0d got %h expected %h", c, diff_lane(bs.out_data, exp_s), bs.out_data[diff_lane(bs.out_data, exp_s)*W +: W], exp_s[diff_lane(bs.out_data, exp_s)*W +: W]); end
        n_checks++; if (bu.out_data !== exp_u) begin n_fail++; $display("FAIL rnd_unsigned: cycle %0d lane %0d got %h expected %h", c, diff_lane(bu.out_data, exp_u), bu.out_data[diff_lane(bu.out_data, exp_u)*W +: W], exp_u[diff_lane(bu.out_data, exp_u)*W +: W]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_window();
    test_signed_relu();
    test_flush_enables();
    test_backpressure();
    test_back_to_back();
    test_boundaries();
    test_reset_mid_window();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
